match_frame_counter: RTL

- Downstream consumer of the serial "1101" Moore pattern detector.
- Counts detector match pulses over fixed-length frames of qualified input bits, then reports each frame's count through a valid/ready output register.
- Counting of the next frame runs while the previous report waits to be read.
- Flags frames lost because the consumer did not read in time, and counts that saturated.

---
 rtl/match_frame_counter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/match_frame_counter.sv
// match_frame_counter
//   Counts "1101" detector match pulses over fixed-length frames of qualified
//   serial bits. Each completed frame's count is handed to a one-entry
//   valid/ready report register. Counting of the next frame continues while
//   an earlier report waits to be read.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   n_rst        asynchronous reset, active HIGH (1 = reset)
//   en           current cycle carries one qualified serial bit
//   match        detector output, counted only together with en
//   frame_start  start / restart a frame
//   stop         abort counting, return to IDLE
//   count_out    reported match count (held while count_valid)
//   ovf_out      reported frame saturated its count
//   count_valid  report register full
//   count_ready  consumer accepts the report
//   frame_lost   sticky: a completed frame was dropped
//   busy         1 while in RUN
module match_frame_counter #(
  parameter int CNT_WIDTH = 8,
  parameter int FRAME_LEN = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 match,
  input  logic                 frame_start,
  input  logic                 stop,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 ovf_out,
  output logic                 count_valid,
  input  logic                 count_ready,
  output logic                 frame_lost,
  output logic                 busy
);

  localparam int BIT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [CNT_WIDTH-1:0] acc_r;
  logic                 sat_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic                 ovf_r;
  logic                 valid_r;
  logic                 lost_r;
  logic                 busy_r;

  logic                 hit_s;
  logic                 last_s;
  logic                 complete_s;
  logic [CNT_WIDTH-1:0] acc_sum_s;
  logic                 sat_sum_s;

  // Saturating accumulator update and frame-completion detect for this cycle.
  always_comb begin
    hit_s     = en & match;
    last_s    = (bit_cnt_r == LAST_BIT);
    acc_sum_s = acc_r;
    sat_sum_s = sat_r;
    if (hit_s && (acc_r == CNT_MAX)) begin
      // Already at max: hold the value, remember the lost match.
      acc_sum_s = acc_r;
      sat_sum_s = 1'b1;
    end else if (hit_s) begin
      acc_sum_s = acc_r + CNT_WIDTH'(1'b1);
      sat_sum_s = sat_r;
    end else begin
      acc_sum_s = acc_r;
      sat_sum_s = sat_r;
    end
    // stop and frame_start both override a completion in the same cycle.
    complete_s = (state_r == RUN) && en && last_s && !stop && !frame_start;
  end

  // Frame FSM: state, bit counter, accumulator and saturation flag.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      bit_cnt_r <= '0;
      acc_r     <= '0;
      sat_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            state_r   <= RUN;
            busy_r    <= 1'b1;
            bit_cnt_r <= '0;
            acc_r     <= '0;
            sat_r     <= 1'b0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            bit_cnt_r <= '0;
            acc_r     <= '0;
            sat_r     <= 1'b0;
          end else if (frame_start || (en && last_s)) begin
            // Restart, or roll straight into the next frame after completion.
            bit_cnt_r <= '0;
            acc_r     <= '0;
            sat_r     <= 1'b0;
          end else if (en) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
            acc_r     <= acc_sum_s;
            sat_r     <= sat_sum_s;
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          bit_cnt_r <= '0;
          acc_r     <= '0;
          sat_r     <= 1'b0;
        end
      endcase
    end
  end

  // Report register with valid/ready handshake and sticky lost-frame flag.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
      lost_r  <= 1'b0;
    end else if (complete_s) begin
      // A report being read this cycle frees the slot for the new result.
      if (!valid_r || count_ready) begin
        count_r <= acc_sum_s;
        ovf_r   <= sat_sum_s;
        valid_r <= 1'b1;
      end else begin
        lost_r <= 1'b1;
      end
    end else if (valid_r && count_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign count_out   = count_r;
  assign ovf_out     = ovf_r;
  assign count_valid = valid_r;
  assign frame_lost  = lost_r;
  assign busy        = busy_r;

endmodule
